// File: rtl/br_pkg.sv
// Shared definitions for the fetch-stage branch predictor: prediction packet layout,
// branch type encodings, reset PC and 2-bit saturating counter helpers.
package br_pkg;

  localparam int unsigned PKT_W     = 76;
  localparam int unsigned TGT_LSB   = 0;
  localparam int unsigned TGT_W     = 32;
  localparam int unsigned VALID_BIT = 32;
  localparam int unsigned TAKEN_BIT = 33;
  localparam int unsigned HIT_BIT   = 34;
  localparam int unsigned CTR_LSB   = 35;
  localparam int unsigned CTR_W     = 2;
  localparam int unsigned TYPE_LSB  = 37;
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned SLOT_BIT  = 39;
  localparam int unsigned RAS_LSB   = 40;

  localparam logic [31:0] RESET_PC  = 32'h1c00_0000;

  typedef enum logic [1:0] {
    BrCond = 2'd0,
    BrJump = 2'd1,
    BrCall = 2'd2,
    BrRet  = 2'd3
  } br_type_e;

  function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
    return (ctr == 2'd3) ? ctr : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
    return (ctr == 2'd0) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/br_ras.sv
// Return-address stack: circular storage with a wrapping pointer. A restore reloads the
// pointer and may be combined with a push in the same cycle.
module br_ras #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             restore,
  input  logic [PTR_W-1:0] restore_ptr,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      push_data,
  output logic [PTR_W-1:0] ptr,
  output logic [31:0]      top
);

  logic [31:0]      stack_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] base;

  // DEPTH is a power of two, so the pointer wraps on overflow and underflow by itself.
  always_comb begin
    base  = restore ? restore_ptr : ptr_q;
    ptr_d = base;
    if (push) begin
      ptr_d = base + PTR_W'(1);
    end else if (pop) begin
      ptr_d = base - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[base] <= push_data;
    end
  end

  assign ptr = ptr_q;
  assign top = stack_q[ptr_q - PTR_W'(1)];

endmodule

// File: rtl/br_predictor.sv
// Fetch-stage branch predictor: direct-mapped two-slot BTB with 2-bit counters, registered
// next fetch PC and per-slot packets. Define BP_RAS_EN to add a return-address stack.
module br_predictor
  import br_pkg::*;
#(
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned TAG_W     = 10,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  input  logic [31:0]      req_pc,
  input  logic             stall,
  output logic             pre_valid,
  output logic [31:0]      npc,
  output logic [PKT_W-1:0] pre0,
  output logic [PKT_W-1:0] pre1,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic [1:0]       upd_type,
  input  logic [PKT_W-1:0] upd_pre,
  input  logic             upd_mispredict
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);

  logic [1:0][ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]        tag_q  [2][ENTRIES];
  logic [31:0]             tgt_q  [2][ENTRIES];
  logic [1:0]              ctr_q  [2][ENTRIES];
  logic [1:0]              type_q [2][ENTRIES];

  logic             pre_valid_q;
  logic [31:0]      npc_q;
  logic [PKT_W-1:0] pre0_q, pre1_q;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             wr_slot, wr_hit, wr_alloc, wr_ctr_en;
  logic [1:0]       wr_ctr;

  logic [1:0]       hit, taken;
  logic [31:0]      tgt [2];
  logic [PKT_W-1:0] pkt [2];
  logic [31:0]      npc_nxt;
  logic [PTR_W-1:0] ras_ptr;

`ifdef BP_RAS_EN
  logic [31:0] ras_top;
  logic [1:0]  is_call, is_ret;
  logic        fire, ras_push, ras_pop;
  logic [31:0] ras_data;
`endif

  assign rd_idx = req_pc[IDX_W+2:3];
  assign rd_tag = req_pc[IDX_W+TAG_W+2:IDX_W+3];

  always_comb begin
    npc_nxt = req_pc + 32'd8;
    for (int s = 0; s < 2; s++) begin
      hit[s]   = valid_q[s][rd_idx] && (tag_q[s][rd_idx] == rd_tag);
      taken[s] = hit[s] && (ctr_q[s][rd_idx][1] || (type_q[s][rd_idx] != BrCond));
      tgt[s]   = hit[s] ? tgt_q[s][rd_idx] : 32'd0;
`ifdef BP_RAS_EN
      if (hit[s] && (type_q[s][rd_idx] == BrRet)) begin
        tgt[s] = ras_top;
      end
`endif
      pkt[s]                      = '0;
      pkt[s][TGT_LSB +: TGT_W]    = tgt[s];
      pkt[s][VALID_BIT]           = 1'b1;
      pkt[s][TAKEN_BIT]           = taken[s];
      pkt[s][HIT_BIT]             = hit[s];
      pkt[s][CTR_LSB +: CTR_W]    = hit[s] ? ctr_q[s][rd_idx] : 2'd0;
      pkt[s][TYPE_LSB +: TYPE_W]  = hit[s] ? type_q[s][rd_idx] : 2'd0;
      pkt[s][SLOT_BIT]            = 1'(s);
      pkt[s][RAS_LSB +: PTR_W]    = ras_ptr;
    end
    // Slot 0 redirecting means slot 1 is never fetched, so it cannot be taken.
    if (taken[0]) begin
      npc_nxt           = tgt[0];
      pkt[1][TAKEN_BIT] = 1'b0;
    end else if (taken[1]) begin
      npc_nxt = tgt[1];
    end
  end

  // Training always reads the live table entry, never the packet snapshot.
  assign wr_slot   = upd_pc[2];
  assign wr_idx    = upd_pc[IDX_W+2:3];
  assign wr_tag    = upd_pc[IDX_W+TAG_W+2:IDX_W+3];
  assign wr_hit    = valid_q[wr_slot][wr_idx] && (tag_q[wr_slot][wr_idx] == wr_tag);
  assign wr_alloc  = upd_valid && upd_taken;
  assign wr_ctr_en = upd_valid && (upd_taken || wr_hit);

  always_comb begin
    if (!wr_hit) begin
      wr_ctr = 2'd2;
    end else if (upd_taken) begin
      wr_ctr = ctr_inc(ctr_q[wr_slot][wr_idx]);
    end else begin
      wr_ctr = ctr_dec(ctr_q[wr_slot][wr_idx]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (wr_alloc) begin
      valid_q[wr_slot][wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_alloc) begin
      tag_q[wr_slot][wr_idx]  <= wr_tag;
      tgt_q[wr_slot][wr_idx]  <= upd_target;
      type_q[wr_slot][wr_idx] <= upd_type;
    end
    if (wr_ctr_en) begin
      ctr_q[wr_slot][wr_idx] <= wr_ctr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_valid_q <= 1'b0;
      npc_q       <= RESET_PC;
      pre0_q      <= '0;
      pre1_q      <= '0;
    end else if (upd_mispredict) begin
      pre_valid_q <= 1'b0;
      pre0_q      <= '0;
      pre1_q      <= '0;
    end else if (!stall) begin
      pre_valid_q <= req_valid;
      if (req_valid) begin
        npc_q  <= npc_nxt;
        pre0_q <= pkt[0];
        pre1_q <= pkt[1];
      end else begin
        pre0_q <= '0;
        pre1_q <= '0;
      end
    end
  end

  assign pre_valid = pre_valid_q;
  assign npc       = npc_q;
  assign pre0      = pre0_q;
  assign pre1      = pre1_q;

`ifdef BP_RAS_EN
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      is_call[s] = hit[s] && (type_q[s][rd_idx] == BrCall);
      is_ret[s]  = hit[s] && (type_q[s][rd_idx] == BrRet);
    end
    fire = req_valid && !stall && !upd_mispredict;
    if (upd_mispredict) begin
      ras_push = (upd_type == BrCall);
      ras_pop  = 1'b0;
      ras_data = upd_pc + 32'd4;
    end else begin
      ras_push = fire && (taken[0] ? is_call[0] : is_call[1]);
      ras_pop  = fire && (taken[0] ? is_ret[0] : is_ret[1]);
      ras_data = taken[0] ? req_pc + 32'd4 : req_pc + 32'd8;
    end
  end

  br_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rstn       (rstn),
    .restore    (upd_mispredict),
    .restore_ptr(upd_pre[RAS_LSB +: PTR_W]),
    .push       (ras_push),
    .pop        (ras_pop),
    .push_data  (ras_data),
    .ptr        (ras_ptr),
    .top        (ras_top)
  );
`else
  assign ras_ptr = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{upd_pc[31:IDX_W+TAG_W+3], upd_pc[1:0], upd_pre};

endmodule

// File: doc/br_predictor.md
Name: br_predictor

Overview:
- Fetch-stage branch predictor. It is the producer of the 76-bit prediction packet that execute-stage branch resolution consumes.
- Each cycle it looks up a two-instruction fetch pair (pc, pc+4) in a direct-mapped BTB with 2-bit counters, and issues the next fetch PC plus a per-slot prediction packet.
- Execute sends resolved outcomes back through a single update port, which trains the tables.

Parameters:
- IDX_W, 6, BTB index bits (64 entries), indexed by pc[IDX_W+2:3].
- TAG_W, 10, tag bits, pc[IDX_W+TAG_W+2:IDX_W+3].
- RAS_DEPTH, 8, return stack entries; used only with BP_RAS_EN.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request this cycle.
- req_pc  in  32  fetch-pair base PC, 8-byte aligned.
- stall  in  1  fetch stalled; hold all outputs.
- pre_valid  out  1  outputs below are valid.
- npc  out  32  predicted next fetch PC.
- pre0  out  76  prediction packet, slot 0.
- pre1  out  76  prediction packet, slot 1.
- upd_valid  in  1  resolved branch from execute.
- upd_pc  in  32  branch PC.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target.
- upd_type  in  2  0 cond, 1 jump, 2 call, 3 return.
- upd_pre  in  76  packet that travelled with the branch.
- upd_mispredict  in  1  fetch is redirected this cycle.

Behaviour:
- Packet layout (pkg): [31:0] predicted target; [32] valid; [33] taken; [34] BTB hit (npc non-sequential candidate); [36:35] counter snapshot; [38:37] type; [39] slot (1 = second of pair); [40+:] RAS pointer snapshot; remaining bits zero.
- Latency: request at cycle T produces outputs registered at T+1.
  - While stall=1, outputs and RAS hold and the request is ignored.
  - pre_valid=0 after a cycle with req_valid=0 and stall=0.
- Hit rule: slot hits when the entry is valid and its tag matches.
- Taken rule: predicted taken if counter ≥ 2, or type ≠ cond.
- npc selection, in priority order:
  - slot0 taken → slot0 target, and pre1.taken is forced to 0;
  - else slot1 taken → slot1 target;
  - else req_pc+8.
- Update (one write per cycle, committed at the clk edge):
  - Hit, taken: counter saturating +1 (max 3); target and type overwritten.
  - Hit, not taken: counter saturating −1 (min 0).
  - Miss, taken: allocate/replace the entry with counter=2.
  - Miss, not taken: no write.
  - The counter is trained from the live table value, not the snapshot.
- Read/write same index in the same cycle: the read returns the old value (no bypass).
- upd_mispredict=1: the outstanding prediction is discarded, so pre_valid=0 next cycle, regardless of req_valid.
- Reset:
  - All valid bits, pre_valid, pre0, pre1 → 0; npc → 32'h1c000000.
  - RAS pointer → 0.
  - Reset is asynchronous and mid-operation safe; no table contents survive.

Optional Feature:
- Macro BP_RAS_EN.
- Defined:
  - Predicted-taken call at prediction time pushes slot PC+4.
  - Predicted return takes its target from the RAS top and pops.
  - Overflow wraps and overwrites the oldest entry; underflow wraps the pointer.
  - On upd_mispredict the pointer is restored from upd_pre; if upd_type=call it is then pushed with upd_pc+4.
- Undefined: returns use the BTB target; the packet RAS field is zero; no stack storage.

Decomposition:
- Package br_pkg holds:
  - packet field offsets/widths;
  - the type encodings;
  - the reset PC;
  - the counter increment/decrement functions.
- One natural sub-module, br_ras (stack plus pointer, push/pop/restore), instantiated only under BP_RAS_EN.

Test Plan:
- Reset, then req_pc=0x1c000000 → next cycle npc=0x1c000008, pre0[34]=pre1[34]=0, pre_valid=1.
- Update cond taken at pc 0x1c000010, target 0x1c000100, miss → request 0x1c000010 gives npc=0x1c000100, pre0[33]=1, counter=2. Then three not-taken updates → counter 0, npc=0x1c000018, and no underflow.
- Taken updates at slot0 (0x1c000020) and slot1 (0x1c000024) → request 0x1c000020 gives npc=slot0 target and pre1[33]=0.
- Stall held 3 cycles with changing req_pc → outputs identical throughout.
- Update and lookup to the same index in the same cycle → lookup sees the old entry; the next lookup sees the new one.
- BP_RAS_EN:
  - call at 0x1c000040, then return → return predicts 0x1c000044;
  - 9 nested calls with depth 8 → the 9th pop returns the wrapped entry;
  - a mispredict restores the pointer from upd_pre.
